// File: rtl/kamus_csr_if.sv
// CSR request/response bundle between kamus_EX and kamus_csr_ctrl.
interface kamus_csr_if;
   logic        csr_req_i;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic        instr_retire_i;
   logic        csr_rdy_o;
   logic        stall_o;
   logic        csr_rvalid_o;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;
   logic        timer_irq_o;

   modport master (
      output csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
      output instr_retire_i,
      input  csr_rdy_o, stall_o, csr_rvalid_o, csr_rdata_o,
      input  csr_illegal_o, timer_irq_o
   );

   modport slave (
      input  csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
      input  instr_retire_i,
      output csr_rdy_o, stall_o, csr_rvalid_o, csr_rdata_o,
      output csr_illegal_o, timer_irq_o
   );
endinterface

// File: rtl/kamus_csr_ctrl.sv
// CSR file, cycle/instret counters and 3-state CSR read-modify-write sequencer.
// Define KAMUS_CSR_TIMER_IRQ_EN to add mtimecmp, mie.MTIE, mip and timer_irq_o.
module kamus_csr_ctrl #(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
   parameter int          CNT_W     = 64
) (
   input logic        clk_i,
   input logic        rst_ni,
   kamus_csr_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RMW, DONE} state_t;

   state_t state_q, state_d;

   logic [1:0]       op_q;
   logic [11:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [CNT_W-1:0] cycle_q, instret_q;
   logic [63:0]      cycle_x, instret_x;
   logic             mie_q;
   logic [31:0]      mtvec_q, mepc_q, mscratch_q, mcause_q;
   logic [31:0]      rdata_q;
   logic             illegal_q;
   logic [31:0]      old_val, new_val;
   logic             known, ro, wr_en, commit, accept;

   assign cycle_x   = 64'(cycle_q);
   assign instret_x = 64'(instret_q);

   assign accept = (state_q == IDLE) & bus.csr_req_i
                 & (bus.csr_op_i != 2'b00);

`ifdef KAMUS_CSR_TIMER_IRQ_EN
   logic        mtie_q;
   logic [63:0] mtimecmp_q;
   logic        irq_q;
   logic        mtip;

   assign mtip = (cycle_x >= mtimecmp_q);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = RMW;
         RMW:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      old_val = '0;
      known   = 1'b1;
      ro      = 1'b0;
      unique case (addr_q)
         12'h300: old_val = {19'b0, 2'b11, 7'b0, mie_q, 3'b0};
         12'h305: old_val = mtvec_q;
         12'h340: old_val = mscratch_q;
         12'h341: old_val = mepc_q;
         12'h342: old_val = mcause_q;
         12'hB00: old_val = cycle_x[31:0];
         12'hB80: old_val = cycle_x[63:32];
         12'hB02: old_val = instret_x[31:0];
         12'hB82: old_val = instret_x[63:32];
         12'hC00, 12'hC01: begin
            old_val = cycle_x[31:0];
            ro      = 1'b1;
         end
         12'hC80, 12'hC81: begin
            old_val = cycle_x[63:32];
            ro      = 1'b1;
         end
         12'hC02: begin
            old_val = instret_x[31:0];
            ro      = 1'b1;
         end
         12'hC82: begin
            old_val = instret_x[63:32];
            ro      = 1'b1;
         end
`ifdef KAMUS_CSR_TIMER_IRQ_EN
         12'h304: old_val = {24'b0, mtie_q, 7'b0};
         12'h344: begin
            old_val = {24'b0, mtip, 7'b0};
            ro      = 1'b1;
         end
         12'h7C0: old_val = mtimecmp_q[31:0];
         12'h7C1: old_val = mtimecmp_q[63:32];
`endif
         default: known = 1'b0;
      endcase
   end

   always_comb begin
      new_val = old_val;
      unique case (op_q)
         2'b01:   new_val = wdata_q;
         2'b10:   new_val = old_val | wdata_q;
         2'b11:   new_val = old_val & ~wdata_q;
         default: new_val = old_val;
      endcase
   end

   // RS/RC with a zero mask are pure reads, legal even on read-only CSRs
   assign wr_en  = (op_q == 2'b01) | (wdata_q != 32'h0);
   assign commit = (state_q == RMW) & known & wr_en & ~ro;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q    <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         op_q    <= bus.csr_op_i;
         addr_q  <= bus.csr_addr_i;
         wdata_q <= bus.csr_wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q   <= '0;
         illegal_q <= 1'b0;
      end else if (state_q == RMW) begin
         rdata_q   <= known ? old_val : 32'h0;
         illegal_q <= ~known | (wr_en & ro);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mie_q      <= 1'b0;
         mtvec_q    <= MTVEC_RST & 32'hFFFF_FFFC;
         mepc_q     <= '0;
         mscratch_q <= '0;
         mcause_q   <= '0;
      end else if (commit) begin
         unique case (addr_q)
            12'h300: mie_q      <= new_val[3];
            12'h305: mtvec_q    <= new_val & 32'hFFFF_FFFC;
            12'h340: mscratch_q <= new_val;
            12'h341: mepc_q     <= new_val & 32'hFFFF_FFFC;
            12'h342: mcause_q   <= new_val;
            default: ;
         endcase
      end
   end

   // A half written by a CSR op holds the other half still that cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_q <= '0;
      end else if (commit && addr_q == 12'hB00) begin
         cycle_q[31:0] <= new_val;
      end else if (commit && addr_q == 12'hB80) begin
         cycle_q[CNT_W-1:32] <= new_val[CNT_W-33:0];
      end else begin
         cycle_q <= cycle_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         instret_q <= '0;
      end else if (commit && addr_q == 12'hB02) begin
         instret_q[31:0] <= new_val;
      end else if (commit && addr_q == 12'hB82) begin
         instret_q[CNT_W-1:32] <= new_val[CNT_W-33:0];
      end else if (bus.instr_retire_i) begin
         instret_q <= instret_q + CNT_W'(1);
      end
   end

`ifdef KAMUS_CSR_TIMER_IRQ_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtie_q     <= 1'b0;
         mtimecmp_q <= '1;
      end else if (commit) begin
         unique case (addr_q)
            12'h304: mtie_q            <= new_val[7];
            12'h7C0: mtimecmp_q[31:0]  <= new_val;
            12'h7C1: mtimecmp_q[63:32] <= new_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) irq_q <= 1'b0;
      else         irq_q <= mtip & mtie_q & mie_q;
   end

   assign bus.timer_irq_o = irq_q;
`else
   assign bus.timer_irq_o = 1'b0;
`endif

   assign bus.csr_rdy_o     = (state_q == IDLE);
   assign bus.stall_o       = ((state_q == IDLE) & bus.csr_req_i)
                            | (state_q == RMW);
   assign bus.csr_rvalid_o  = (state_q == DONE);
   assign bus.csr_rdata_o   = (state_q == DONE) ? rdata_q : 32'h0;
   assign bus.csr_illegal_o = (state_q == DONE) & illegal_q;

endmodule

// File: tb/tb_kamus_csr_ctrl.sv
// Scoreboard bench for kamus_csr_ctrl with a transaction-level CSR model.
// Honours KAMUS_CSR_TIMER_IRQ_EN the same way as the design.
module tb_kamus_csr_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   kamus_csr_if bus();

   kamus_csr_ctrl dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        ill;
      logic [11:0] addr;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   logic [63:0] m_cycle, m_instret, m_cmp;
   logic [31:0] m_mtvec, m_mepc, m_mscratch, m_mcause;
   logic        m_mie, m_mtie, m_irq;
   bit          pend;
   logic [11:0] pend_addr;
   logic [31:0] pend_val;

   logic [11:0] alist [0:20] = '{
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
      12'hC01, 12'hC80, 12'hC81, 12'hC02, 12'hC82,
      12'h304, 12'h344, 12'h7C0, 12'h7C1, 12'h123, 12'hFFF
   };

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cycle    = '0;
      m_instret  = '0;
      m_cmp      = '1;
      m_mtvec    = 32'h0;
      m_mepc     = '0;
      m_mscratch = '0;
      m_mcause   = '0;
      m_mie      = 1'b0;
      m_mtie     = 1'b0;
      m_irq      = 1'b0;
      pend       = 1'b0;
   endtask

   function automatic void mread(input logic [11:0] a, output logic kn,
                                 output logic rdo, output logic [31:0] v);
      kn  = 1'b1;
      rdo = 1'b0;
      v   = 32'h0;
      case (a)
         12'h300: v = 32'h1800 | (32'(m_mie) << 3);
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'hB00: v = m_cycle[31:0];
         12'hB80: v = m_cycle[63:32];
         12'hB02: v = m_instret[31:0];
         12'hB82: v = m_instret[63:32];
         12'hC00, 12'hC01: begin v = m_cycle[31:0]; rdo = 1'b1; end
         12'hC80, 12'hC81: begin v = m_cycle[63:32]; rdo = 1'b1; end
         12'hC02: begin v = m_instret[31:0]; rdo = 1'b1; end
         12'hC82: begin v = m_instret[63:32]; rdo = 1'b1; end
`ifdef KAMUS_CSR_TIMER_IRQ_EN
         12'h304: v = 32'(m_mtie) << 7;
         12'h344: begin v = 32'(m_cycle >= m_cmp) << 7; rdo = 1'b1; end
         12'h7C0: v = m_cmp[31:0];
         12'h7C1: v = m_cmp[63:32];
`endif
         default: kn = 1'b0;
      endcase
   endfunction

   // One clock edge of the reference model, applying any pending CSR commit
   task automatic step();
      logic [63:0] c0, i0;
      logic        irq_n;
      irq_n = (m_cycle >= m_cmp) & m_mtie & m_mie;
      c0 = m_cycle;
      i0 = m_instret;
      @(posedge clk);
      if (rst_n) begin
         m_irq   = irq_n;
         m_cycle = c0 + 64'd1;
         if (bus.instr_retire_i) m_instret = i0 + 64'd1;
         if (pend) begin
            case (pend_addr)
               12'hB00: m_cycle   = {c0[63:32], pend_val};
               12'hB80: m_cycle   = {pend_val, c0[31:0]};
               12'hB02: m_instret = {i0[63:32], pend_val};
               12'hB82: m_instret = {pend_val, i0[31:0]};
               12'h300: m_mie      = pend_val[3];
               12'h305: m_mtvec    = pend_val & 32'hFFFF_FFFC;
               12'h340: m_mscratch = pend_val;
               12'h341: m_mepc     = pend_val & 32'hFFFF_FFFC;
               12'h342: m_mcause   = pend_val;
               12'h304: m_mtie     = pend_val[7];
               12'h7C0: m_cmp[31:0]  = pend_val;
               12'h7C1: m_cmp[63:32] = pend_val;
               default: ;
            endcase
            pend = 1'b0;
         end
      end
      #1;
   endtask

   task automatic txn(input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input int fret);
      logic        kn, rdo, wr;
      logic [31:0] ov, nv;
      exp_t        e;
      bus.csr_req_i      = 1'b1;
      bus.csr_op_i       = op;
      bus.csr_addr_i     = a;
      bus.csr_wdata_i    = wd;
      bus.instr_retire_i = 1'($urandom_range(0, 1));
      #1;
      check("stall_T", 64'(bus.stall_o), 64'd1);
      check("rdy_T", 64'(bus.csr_rdy_o), 64'd1);
      step();
      bus.csr_req_i   = 1'($urandom_range(0, 1));
      bus.csr_op_i    = 2'($urandom);
      bus.csr_addr_i  = 12'($urandom);
      bus.csr_wdata_i = $urandom;
      mread(a, kn, rdo, ov);
      wr = (op == 2'b01) || (wd != 32'h0);
      case (op)
         2'b01:   nv = wd;
         2'b10:   nv = ov | wd;
         default: nv = ov & ~wd;
      endcase
      e.rdata = kn ? ov : 32'h0;
      e.ill   = !kn || (wr && rdo);
      e.addr  = a;
      sb.push_back(e);
      if (kn && wr && !rdo) begin
         pend      = 1'b1;
         pend_addr = a;
         pend_val  = nv;
      end
      check("stall_T1", 64'(bus.stall_o), 64'd1);
      check("rdy_T1", 64'(bus.csr_rdy_o), 64'd0);
      if (fret >= 0) bus.instr_retire_i = 1'(fret);
      else bus.instr_retire_i = 1'($urandom_range(0, 1));
      step();
      bus.csr_req_i = 1'b0;
      bus.instr_retire_i = 1'($urandom_range(0, 1));
      check("stall_T2", 64'(bus.stall_o), 64'd0);
      check("rvalid_T2", 64'(bus.csr_rvalid_o), 64'd1);
      step();
      check("rdy_T3", 64'(bus.csr_rdy_o), 64'd1);
   endtask

   always @(negedge clk) begin
      if (bus.csr_rvalid_o) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got rdata %h expected no response",
                     bus.csr_rdata_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("rdata@%h", e.addr), 64'(bus.csr_rdata_o),
                  64'(e.rdata));
            check($sformatf("illegal@%h", e.addr), 64'(bus.csr_illegal_o),
                  64'(e.ill));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.csr_req_i      = 1'b0;
      bus.csr_op_i       = 2'b00;
      bus.csr_addr_i     = '0;
      bus.csr_wdata_i    = '0;
      bus.instr_retire_i = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) step();
      check("rst_rvalid", 64'(bus.csr_rvalid_o), 64'd0);
      check("rst_stall", 64'(bus.stall_o), 64'd0);
      check("rst_rdata", 64'(bus.csr_rdata_o), 64'd0);
      check("rst_illegal", 64'(bus.csr_illegal_o), 64'd0);
      check("rst_irq", 64'(bus.timer_irq_o), 64'd0);
      rst_n = 1'b1;
      repeat (10) step();
      check("rdy_idle", 64'(bus.csr_rdy_o), 64'd1);

      txn(2'b01, 12'hC00, 32'h0, 0);

      txn(2'b01, 12'h340, 32'hA5A5_0003, -1);
      txn(2'b10, 12'h340, 32'h0000_0F00, -1);
      txn(2'b11, 12'h340, 32'h0000_0001, -1);
      txn(2'b10, 12'h340, 32'h0, -1);
      check("mscratch_final", 64'(m_mscratch), 64'h0000_0000_A5A5_0F02);

      txn(2'b01, 12'hC80, 32'h1, -1);
      txn(2'b10, 12'hC80, 32'h0, -1);
      txn(2'b10, 12'hC00, 32'h0, -1);

      txn(2'b01, 12'hB80, 32'hFFFF_FFFF, -1);
      txn(2'b01, 12'hB00, 32'hFFFF_FFFF, -1);
      txn(2'b10, 12'hB00, 32'h0, -1);
      txn(2'b10, 12'hB80, 32'h0, -1);
      txn(2'b01, 12'hB02, 32'h0000_1234, 1);
      txn(2'b01, 12'hB82, 32'h0000_0007, 1);
      txn(2'b10, 12'hB02, 32'h0, 0);
      txn(2'b10, 12'hB82, 32'h0, 0);

      // Non-request op code: stall follows req, but nothing is accepted
      bus.csr_req_i = 1'b1;
      bus.csr_op_i  = 2'b00;
      #1;
      check("op00_stall", 64'(bus.stall_o), 64'd1);
      step();
      check("op00_rdy", 64'(bus.csr_rdy_o), 64'd1);
      bus.csr_req_i = 1'b0;
      step();

      bus.csr_req_i   = 1'b1;
      bus.csr_op_i    = 2'b01;
      bus.csr_addr_i  = 12'h305;
      bus.csr_wdata_i = 32'h1234_5678;
      step();
      rst_n = 1'b0;
      bus.csr_req_i = 1'b0;
      model_reset();
      #1;
      check("rstmid_rvalid", 64'(bus.csr_rvalid_o), 64'd0);
      check("rstmid_rdy", 64'(bus.csr_rdy_o), 64'd1);
      check("rstmid_stall", 64'(bus.stall_o), 64'd0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      txn(2'b10, 12'h305, 32'h0, -1);
      txn(2'b01, 12'h305, 32'h1234_5678, -1);
      txn(2'b10, 12'h305, 32'h0, -1);
      check("mtvec_model", 64'(m_mtvec), 64'h1234_5678);

`ifdef KAMUS_CSR_TIMER_IRQ_EN
      txn(2'b01, 12'h7C1, 32'h0, -1);
      txn(2'b01, 12'h7C0, 32'd100, -1);
      txn(2'b01, 12'h304, 32'h80, -1);
      txn(2'b10, 12'h300, 32'h8, -1);
      for (int i = 0; i < 120; i++) begin
         step();
         check("timer_irq", 64'(bus.timer_irq_o), 64'(m_irq));
      end
      check("timer_irq_high", 64'(bus.timer_irq_o), 64'd1);
      txn(2'b10, 12'h344, 32'h0, -1);
`else
      txn(2'b01, 12'h7C0, 32'd100, -1);
      txn(2'b01, 12'h304, 32'h80, -1);
      txn(2'b10, 12'h300, 32'h8, -1);
      for (int i = 0; i < 20; i++) begin
         step();
         check("timer_irq_off", 64'(bus.timer_irq_o), 64'd0);
      end
`endif

      for (int i = 0; i < 150; i++) begin
         logic [1:0]  op;
         logic [31:0] wd;
         op = 2'($urandom_range(1, 3));
         wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         txn(op, alist[$urandom_range(0, 20)], wd, -1);
      end

      repeat (3) step();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
